// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MiniRISC fetch path: owns the PC, the
// run/stall/halt FSM and the link register, and steps through an external +1 incrementer.
module pc_sequencer #(
   parameter int unsigned WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             branch_taken,
   input  logic             branch_link,
   input  logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] inc_operand,
   input  logic [WIDTH-1:0] inc_result,
   output logic [WIDTH-1:0] pc,
   output logic             pc_valid,
   output logic [WIDTH-1:0] link_addr,
   output logic             wrap,
   output logic             halted,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      STALL = 2'b10,
      HALT  = 2'b11
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] link_q;
   logic [WIDTH-1:0] link_d;
   logic             wrap_q;
   logic             wrap_d;

   logic             run_seq;
   logic             run_branch;
   logic             pc_all_ones;

   // RUN-state decode in priority order: halt, then stall, then branch, then sequential step.
   assign run_branch  = (state_q == RUN) && !halt_req && !stall && branch_taken;
   assign run_seq     = (state_q == RUN) && !halt_req && !stall && !branch_taken;
   assign pc_all_ones = (pc_q == {WIDTH{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         link_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         link_q  <= link_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (halt_req)   state_d = HALT;
            else if (stall) state_d = STALL;
         end
         STALL: begin
            if (halt_req)    state_d = HALT;
            else if (!stall) state_d = RUN;
         end
         HALT: begin
            if (start) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequential PCs always come from the shared incrementer, never from a local adder.
   always_comb begin
      pc_d   = pc_q;
      link_d = link_q;
      wrap_d = 1'b0;
      if (run_branch) begin
         pc_d = branch_target;
         if (branch_link) link_d = inc_result;
      end else if (run_seq) begin
         pc_d   = inc_result;
         wrap_d = pc_all_ones;
      end
   end

   assign inc_operand = pc_q;
   assign pc          = pc_q;
   assign link_addr   = link_q;
   assign wrap        = wrap_q;
   assign state       = state_q;
   assign pc_valid    = (state_q == RUN);
   assign halted      = (state_q == HALT);

endmodule
